mmio_input_injector: RTL and testbench

- Sits between the touch-screen controller's input interface and the data-memory write arbiter.
- Captures each touch-entered value (input_valid/input_value/input_sel) into a small FIFO.
- Replays each entry as a single-word write request to INPUT1_ADDR or INPUT2_ADDR, using a req/gnt handshake.
- Replaces the ad-hoc enable counters with a lossless, back-pressured path. Keeps committed-value shadow registers for the display mux.

---
 rtl/mmio_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/mmio_input_injector.sv | 160 ++++++++++++++++
 tb/tb_mmio_input_injector.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped input/output registers
// of the touch-screen datapath.
package mmio_pkg;

  // Data-memory word addresses of the touch-entered inputs.
  localparam logic [31:0] INPUT1_ADDR  = 32'h0000_0000;
  localparam logic [31:0] INPUT2_ADDR  = 32'h0000_0004;
  // Output-side registers read back by the display path; not written here.
  localparam logic [31:0] OUTPUT1_ADDR = 32'h0000_0008;
  localparam logic [31:0] OUTPUT2_ADDR = 32'h0000_000C;

  // One queued entry is {sel, value}.
  localparam int unsigned ENTRY_W = 33;

  typedef struct packed {
    logic        sel;
    logic [31:0] value;
  } entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } inj_state_t;

  // Select between the two input word addresses.
  function automatic logic [31:0] sel_addr(input logic        sel,
                                           input logic [31:0] addr1,
                                           input logic [31:0] addr2);
    return sel ? addr2 : addr1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. Besides push/pop it exposes the
// youngest entry and lets it be overwritten in place (used for coalescing).
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     tail_wr,
  input  logic [WIDTH-1:0]         tail_wdata,
  output logic [WIDTH-1:0]         tail_rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    tail_idx;

  assign wr_idx   = wr_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];
  assign tail_idx = wr_idx - AW'(1);

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign count      = wr_ptr - rd_ptr;
  assign rdata      = mem[rd_idx];
  assign tail_rdata = mem[tail_idx];

  // Advance pointers; a push while full is only issued together with a pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write: new entry at the write slot, or in-place update of the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= wdata;
    end else if (tail_wr) begin
      mem[tail_idx] <= tail_wdata;
    end
  end

endmodule

// File: rtl/mmio_input_injector.sv
// Queues touch-screen entries and replays each as a single-word DM write
// through a req/gnt handshake, keeping shadow copies of committed values.
// Optional build macro MMIO_INJ_COALESCE_EN: an entry with the same sel as
// the youngest queued entry overwrites it instead of taking a new slot.
//
// state | meaning
// IDLE  | no write outstanding; pops the FIFO head when one is queued
// REQ   | dm_req high with address/data held until dm_gnt
module mmio_input_injector
  import mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] INPUT1_ADDR = mmio_pkg::INPUT1_ADDR,
  parameter logic [31:0] INPUT2_ADDR = mmio_pkg::INPUT2_ADDR,
  parameter int unsigned DROP_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  input_valid,
  input  logic                  input_sel,
  input  logic [31:0]           input_value,
  output logic                  dm_req,
  output logic [31:0]           dm_addr,
  output logic [31:0]           dm_wdata,
  input  logic                  dm_gnt,
  output logic [31:0]           in1_value,
  output logic [31:0]           in2_value,
  output logic                  pending,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  drop_clr
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;

  entry_t        in_entry;
  entry_t        head_entry;
  entry_t        tail_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [PW-1:0] fifo_count;
  logic          coalesce;
  logic          drop;

  inj_state_t    state;
  inj_state_t    state_nxt;
  logic          load;
  logic          commit;
  logic          req_sel;

  assign in_entry = '{sel: input_sel, value: input_value};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .wdata      (in_entry),
    .rdata      (head_entry),
    .tail_wr    (coalesce),
    .tail_wdata (in_entry),
    .tail_rdata (tail_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

`ifdef MMIO_INJ_COALESCE_EN
  // The tail is off limits when it is also the head leaving on this edge.
  assign coalesce = input_valid && !fifo_empty && (tail_entry.sel == input_sel) &&
                    !(fifo_pop && (fifo_count == PW'(1)));
`else
  logic unused_tail;
  assign unused_tail = ^{tail_entry, fifo_count};
  assign coalesce    = 1'b0;
`endif

  // A full FIFO still accepts an entry when the head leaves on the same edge.
  assign fifo_push = input_valid && !coalesce && (!fifo_full || fifo_pop);
  assign drop      = input_valid && !coalesce && fifo_full && !fifo_pop;

  assign dm_req  = (state == REQ);
  assign pending = !fifo_empty || dm_req;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the pop/load/commit strobes.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (dm_gnt) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the popped head as the outstanding write; held for all of REQ.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dm_addr  <= '0;
      dm_wdata <= '0;
      req_sel  <= 1'b0;
    end else if (load) begin
      dm_addr  <= sel_addr(head_entry.sel, INPUT1_ADDR, INPUT2_ADDR);
      dm_wdata <= head_entry.value;
      req_sel  <= head_entry.sel;
    end
  end

  // Shadow copies follow only writes the arbiter has accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in1_value <= '0;
      in2_value <= '0;
    end else if (commit) begin
      if (req_sel) begin
        in2_value <= dm_wdata;
      end else begin
        in1_value <= dm_wdata;
      end
    end
  end

  // Saturating overflow counter; a clear wins over a same-cycle drop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mmio_input_injector.sv
// Self-checking bench for mmio_input_injector: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_mmio_input_injector;

  localparam int DEPTH    = 4;
  localparam int DROP_MAX = 255;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        input_valid = 1'b0;
  logic        input_sel = 1'b0;
  logic [31:0] input_value = '0;
  logic        dm_gnt = 1'b0;
  logic        drop_clr = 1'b0;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] in1_value;
  logic [31:0] in2_value;
  logic        pending;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_input_injector dut (
    .clk         (clk),
    .resetn      (resetn),
    .input_valid (input_valid),
    .input_sel   (input_sel),
    .input_value (input_value),
    .dm_req      (dm_req),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_gnt      (dm_gnt),
    .in1_value   (in1_value),
    .in2_value   (in2_value),
    .pending     (pending),
    .drop_cnt    (drop_cnt),
    .drop_clr    (drop_clr)
  );

  // Reference model: queued entries, one in-flight write, shadows, drops.
  typedef struct packed {
    logic        sel;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy;
  ent_t        m_cur;
  logic [31:0] m_in1;
  logic [31:0] m_in2;
  int          m_drop;
  logic [63:0] m_log[$];
  logic [63:0] dut_log[$];

  function automatic logic [31:0] addr_of(input logic sel);
    return sel ? 32'h0000_0004 : 32'h0000_0000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = 0;
    m_cur  = '0;
    m_in1  = '0;
    m_in2  = '0;
    m_drop = 0;
  endtask

  task automatic model_step(input bit iv, input bit sel, input logic [31:0] val,
                            input bit gnt, input bit clr);
    bit pop;
    bit coal;
    bit dropped;
    pop     = !m_busy && (mq.size() > 0);
    coal    = 0;
    dropped = 0;
`ifdef MMIO_INJ_COALESCE_EN
    if (iv && mq.size() > 0 && mq[mq.size()-1].sel == sel && !(pop && mq.size() == 1)) begin
      coal = 1;
      mq[mq.size()-1].val = val;
    end
`endif
    if (m_busy && gnt) begin
      if (m_cur.sel) m_in2 = m_cur.val;
      else           m_in1 = m_cur.val;
      m_log.push_back({addr_of(m_cur.sel), m_cur.val});
      m_busy = 0;
    end else if (pop) begin
      m_cur  = mq.pop_front();
      m_busy = 1;
    end
    if (iv && !coal) begin
      if (mq.size() < DEPTH) mq.push_back('{sel: sel, val: val});
      else                   dropped = 1;
    end
    if (clr)                               m_drop = 0;
    else if (dropped && m_drop < DROP_MAX) m_drop++;
  endtask

  // Drive one cycle of inputs (called just after a rising edge), log any
  // accepted write, advance the model at the edge, then settle.
  task automatic cycle(input bit iv, input bit sel, input logic [31:0] val,
                       input bit gnt, input bit clr);
    input_valid = iv;
    input_sel   = sel;
    input_value = val;
    dm_gnt      = gnt;
    drop_clr    = clr;
    if (dm_req && gnt) dut_log.push_back({dm_addr, dm_wdata});
    @(posedge clk);
    model_step(iv, sel, val, gnt, clr);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(0, 0, '0, 1, 0);
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if ({dm_req, dm_addr, dm_wdata, in1_value, in2_value, drop_cnt, pending} !== '0) begin
      errors++;
      $display("FAIL reset_state req=%b addr=%h wdata=%h in1=%h in2=%h drop=%0d pend=%b want all zero",
               dm_req, dm_addr, dm_wdata, in1_value, in2_value, drop_cnt, pending);
    end
    @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  task automatic test_single();
    dut_log.delete();
    cycle(1, 0, 32'h0000_00A5, 1, 0);
    checks++;
    if (dm_req !== 1'b0 || pending !== 1'b1) begin
      errors++;
      $display("FAIL single_edgeN req=%b pend=%b want req=0 pend=1", dm_req, pending);
    end
    cycle(0, 0, '0, 1, 0);
    checks++;
    if (dm_req !== 1'b1 || dm_addr !== 32'h0 || dm_wdata !== 32'hA5 || in1_value !== 32'h0) begin
      errors++;
      $display("FAIL single_req req=%b addr=%h wdata=%h in1=%h want 1/0/a5/0",
               dm_req, dm_addr, dm_wdata, in1_value);
    end
    cycle(0, 0, '0, 1, 0);
    checks++;
    if (dm_req !== 1'b0 || in1_value !== 32'hA5 || pending !== 1'b0) begin
      errors++;
      $display("FAIL single_commit req=%b in1=%h pend=%b want 0/a5/0", dm_req, in1_value, pending);
    end
    drain(2);
    checks++;
    if (dut_log.size() != 1) begin
      errors++;
      $display("FAIL single_count writes=%0d want 1", dut_log.size());
    end
  endtask

  task automatic test_back_pressure();
    int bad;
    dut_log.delete();
    cycle(1, 1, 32'd7, 0, 0);
    cycle(1, 0, 32'd9, 0, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, '0, 0, 0);
      if (dm_req !== 1'b1 || dm_addr !== 32'h4 || dm_wdata !== 32'd7) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold unstable_cycles=%0d want 0 (req=%b addr=%h wdata=%h)",
               bad, dm_req, dm_addr, dm_wdata);
    end
    drain(6);
    checks++;
    if (dut_log.size() != 2 || dut_log[0] !== {32'h4, 32'd7} || dut_log[1] !== {32'h0, 32'd9}) begin
      errors++;
      $display("FAIL bp_order writes=%0d first=%h want 2 writes 4:7 then 0:9",
               dut_log.size(), (dut_log.size() > 0) ? dut_log[0] : 64'h0);
    end
    checks++;
    if (in2_value !== 32'd7 || in1_value !== 32'd9) begin
      errors++;
      $display("FAIL bp_shadow in1=%h in2=%h want 9/7", in1_value, in2_value);
    end
  endtask

  task automatic test_overflow();
    bit s;
    dut_log.delete();
    for (int i = 1; i <= 6; i++) begin
`ifdef MMIO_INJ_COALESCE_EN
      s = i[0];
`else
      s = 1'b0;
`endif
      cycle(1, s, 32'(i), 0, 0);
    end
    checks++;
    if (drop_cnt !== 8'd1 || dm_req !== 1'b1 || dm_wdata !== 32'd1) begin
      errors++;
      $display("FAIL ovf_drop drop=%0d req=%b wdata=%h want 1/1/1", drop_cnt, dm_req, dm_wdata);
    end
    drain(12);
    checks++;
    if (dut_log.size() != 5) begin
      errors++;
      $display("FAIL ovf_count writes=%0d want 5", dut_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (dut_log[i][31:0] !== 32'(i + 1)) begin
          errors++;
          $display("FAIL ovf_data idx=%0d got=%h want=%h", i, dut_log[i][31:0], i + 1);
        end
      end
    end
    cycle(0, 0, '0, 0, 1);
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ovf_clr drop=%0d want 0", drop_cnt);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] want [6];
    dut_log.delete();
    for (int i = 0; i < 5; i++) begin
      cycle(1, i[0], 32'h10 + 32'(i), 0, 0);
      want[i] = 32'h10 + 32'(i);
    end
    want[5] = 32'h20;
    cycle(0, 0, '0, 1, 0);
    cycle(1, 1, 32'h20, 0, 0);
    checks++;
    if (drop_cnt !== 8'd0 || dm_req !== 1'b1 || dm_wdata !== 32'h11 || pending !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_accept drop=%0d req=%b wdata=%h pend=%b want 0/1/11/1",
               drop_cnt, dm_req, dm_wdata, pending);
    end
    drain(14);
    checks++;
    if (dut_log.size() != 6) begin
      errors++;
      $display("FAIL fullpop_count writes=%0d want 6", dut_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (dut_log[i][31:0] !== want[i]) begin
          errors++;
          $display("FAIL fullpop_data idx=%0d got=%h want=%h", i, dut_log[i][31:0], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1, i[0], 32'h40 + 32'(i), 0, 0);
    input_valid = 1'b0;
    checks++;
    if (dm_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre req=%b want 1", dm_req);
    end
    #3 resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dm_req !== 1'b0 || in1_value !== 32'h0 || in2_value !== 32'h0 ||
        pending !== 1'b0 || dm_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async req=%b in1=%h in2=%h pend=%b addr=%h want all zero",
               dm_req, in1_value, in2_value, pending, dm_addr);
    end
    @(posedge clk);
    #2 resetn = 1'b1;
    dut_log.delete();
    drain(10);
    checks++;
    if (dut_log.size() != 0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nowrites writes=%0d pend=%b want 0/0", dut_log.size(), pending);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) cycle(1, i[0], 32'(i), 0, 0);
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_drop drop=%0d want 255", drop_cnt);
    end
    cycle(1, 0, 32'h55, 0, 1);
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL sat_clr_priority drop=%0d want 0", drop_cnt);
    end
    drain(14);
  endtask

  task automatic test_coalesce();
    dut_log.delete();
    cycle(1, 0, 32'd1, 0, 0);
    cycle(1, 1, 32'd2, 0, 0);
    cycle(1, 1, 32'd3, 0, 0);
    drain(10);
`ifdef MMIO_INJ_COALESCE_EN
    checks++;
    if (dut_log.size() != 2 || dut_log[0] !== {32'h0, 32'd1} || dut_log[1] !== {32'h4, 32'd3}) begin
      errors++;
      $display("FAIL coalesce_writes n=%0d want 0:1 then 4:3", dut_log.size());
    end
`else
    checks++;
    if (dut_log.size() != 3 || dut_log[0] !== {32'h0, 32'd1} || dut_log[1] !== {32'h4, 32'd2} ||
        dut_log[2] !== {32'h4, 32'd3}) begin
      errors++;
      $display("FAIL coalesce_writes n=%0d want 0:1, 4:2, 4:3", dut_log.size());
    end
`endif
    checks++;
    if (in2_value !== 32'd3 || in1_value !== 32'd1) begin
      errors++;
      $display("FAIL coalesce_shadow in1=%h in2=%h want 1/3", in1_value, in2_value);
    end
  endtask

  task automatic test_random();
    int bad;
    bit iv, gnt, clr;
    m_log.delete();
    dut_log.delete();
    for (int i = 0; i < 800; i++) begin
      iv  = ($urandom_range(0, 99) < 55);
      gnt = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 3);
      cycle(iv, 1'($urandom_range(0, 1)), $urandom, gnt, clr);
      bad = 0;
      if (dm_req !== m_busy) bad++;
      if (m_busy && (dm_addr !== addr_of(m_cur.sel) || dm_wdata !== m_cur.val)) bad++;
      if (in1_value !== m_in1 || in2_value !== m_in2) bad++;
      if (drop_cnt !== 8'(m_drop)) bad++;
      if (pending !== (m_busy || mq.size() > 0)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_cycle i=%0d req=%b/%b wdata=%h/%h in1=%h/%h in2=%h/%h drop=%0d/%0d pend=%b (got/want)",
                 i, dm_req, m_busy, dm_wdata, m_cur.val, in1_value, m_in1, in2_value, m_in2,
                 drop_cnt, m_drop, pending);
      end
    end
    drain(12);
    checks++;
    if (dut_log != m_log) begin
      errors++;
      $display("FAIL rand_log writes=%0d want %0d", dut_log.size(), m_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_saturate();
    test_coalesce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
